// File: rtl/piso_sched_pkg.sv
// Shared types and width helpers for the round-robin PISO scheduler.
// PISO_SCHED_PARITY_EN adds the PARITY state to the FSM encoding.
package piso_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
`ifdef PISO_SCHED_PARITY_EN
      SHIFT,
      PARITY
`else
      SHIFT
`endif
   } state_t;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   function automatic int id_width(input int num_req);
      return $clog2(num_req);
   endfunction

endpackage

// File: rtl/piso_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester;
// the pointer moves only when the caller signals a completed handshake.
module rr_arbiter
   import piso_sched_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               enable,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    id
);

   logic [ID_W-1:0] last_reg;
   logic            found;
   int              idx;

   always_comb begin
      grant = '0;
      id    = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(last_reg) + 1 + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            id    = ID_W'(idx);
         end
      end
      if (enable && found) grant[id] = 1'b1;
   end

   // Reset parks the pointer on the last requester so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       last_reg <= ID_W'(NUM_REQ - 1);
      else if (advance) last_reg <= id;
   end

endmodule

// File: rtl/piso_scheduler.sv
// Shares one MSB-first shifter between NUM_REQ producers with round-robin grants.
// Define PISO_SCHED_PARITY_EN to append an even-parity bit to every frame.
module piso_scheduler
   import piso_sched_pkg::*;
#(
   parameter  int WIDTH   = 16,
   parameter  int NUM_REQ = 4,
   localparam int CNT_W   = cnt_width(WIDTH),
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic                     stall,
   output logic                     ser_out,
   output logic                     ser_valid,
   output logic                     ser_first,
   output logic                     ser_last,
   output logic [ID_W-1:0]          grant_id,
   output logic                     busy,
   output logic                     word_done
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   shreg_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [ID_W-1:0]    grant_id_reg;
   logic [ID_W-1:0]    win_id;
   logic [WIDTH-1:0]   win_word;
   logic               handshake;
   logic               last_bit;
`ifdef PISO_SCHED_PARITY_EN
   logic               parity_reg;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .enable  (state_reg == IDLE && !stall),
      .advance (handshake),
      .grant   (req_ready),
      .id      (win_id)
   );

   assign handshake = |(req_valid & req_ready);
   assign win_word  = req_data[int'(win_id)*WIDTH +: WIDTH];
   assign last_bit  = (state_reg == SHIFT) && (cnt_reg == CNT_LAST);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (handshake) state_next = SHIFT;
`ifdef PISO_SCHED_PARITY_EN
         SHIFT:  if (!stall && last_bit) state_next = PARITY;
         PARITY: if (!stall) state_next = IDLE;
`else
         SHIFT: if (!stall && last_bit) state_next = IDLE;
`endif
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_reg    <= '0;
         cnt_reg      <= '0;
         grant_id_reg <= '0;
`ifdef PISO_SCHED_PARITY_EN
         parity_reg   <= 1'b0;
`endif
      end else if (state_reg == IDLE) begin
         if (handshake) begin
            shreg_reg    <= win_word;
            cnt_reg      <= '0;
            grant_id_reg <= win_id;
`ifdef PISO_SCHED_PARITY_EN
            parity_reg   <= ^win_word;
`endif
         end
      end else if (state_reg == SHIFT && !stall) begin
         // Zero fill leaves the shifter clear, so ser_out idles low.
         shreg_reg <= shreg_reg << 1;
         cnt_reg   <= last_bit ? '0 : cnt_reg + 1'b1;
      end
   end

   // Outputs come straight from state registers, qualified by stall.
`ifdef PISO_SCHED_PARITY_EN
   assign ser_out  = (state_reg == PARITY) ? parity_reg : shreg_reg[WIDTH-1];
   assign ser_last = (state_reg == PARITY) && !stall;
`else
   assign ser_out  = shreg_reg[WIDTH-1];
   assign ser_last = last_bit && !stall;
`endif
   assign ser_valid = (state_reg != IDLE) && !stall;
   assign ser_first = (state_reg == SHIFT) && (cnt_reg == '0) && !stall;
   assign word_done = ser_last;
   assign busy      = (state_reg != IDLE);
   assign grant_id  = grant_id_reg;

endmodule
